// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter around a 16-bit 4:1 word multiplexer: drives the selects,
// captures the returned word into a valid/ready output and acks the served channel.
module mux4_rr_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  output logic [3:0]       ack,
  output logic             s0,
  output logic             s1,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t     state, state_nxt;
  logic [1:0] last;
  logic [1:0] sel;
  logic [1:0] pick;
  logic [3:0] elig;
  logic       any_elig;
  logic       load_sel;

  // First requester found scanning last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] e);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (e[idx]) rr_pick = idx;
    end
  endfunction

  // A channel whose ack is on the wire this cycle has not yet dropped its req.
  assign elig     = req & ~ack;
  assign any_elig = |elig;
  assign pick     = rr_pick(last, elig);
  assign {s1, s0} = sel;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_sel  = 1'b0;
    case (state)
      IDLE: begin
        if (any_elig) begin
          state_nxt = GRANT;
          load_sel  = 1'b1;
        end
      end
      GRANT: state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (any_elig) begin
            state_nxt = GRANT;
            load_sel  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= '0;
      sel       <= '0;
      last      <= 2'd3;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      ack <= '0;
      if (load_sel) sel <= pick;
      if (state == GRANT) begin
        out_data  <= mux_out;
        out_valid <= 1'b1;
        ack       <= 4'b0001 << sel;
        last      <= sel;
      end
      if (state == HOLD && out_ready) out_valid <= 1'b0;
    end
  end

endmodule
